sram_access_seq: RTL and testbench
==================================

# sram_access_seq

Pin-level SRAM access sequencer for the SRAM/counter demo. It sits between the demo control FSM and the board pins. It accepts one write, read or rewind command at a time over a valid/ready handshake. It generates WE_BAR, data-bus drive enable, external counter (MC14040B) clock and reset with legal pulse widths, and returns read words to the FSM. The FSM no longer touches pins directly. The 8-bit word maps to CHIP1 in [7:4] and CHIP2 in [3:0]. The top level instantiates the tristate buffers.

## Interface
- DATA_W, 8, word width (CHIP1 upper nibble, CHIP2 lower nibble)
- ADDR_W, 4, width of the tracked counter address (wraps modulo 2^ADDR_W)
- CNT_HALF, 50, CLK cycles per counter-clock half period and counter-reset width (≥50 at 100 MHz keeps the counter ≤1 MHz)
- SETUP_CYC, 2, cycles data is driven before WE_BAR falls
- WE_CYC, 4, WE_BAR low width in cycles
- READ_CYC, 3, cycles from bus release to DATA_IN sample
- CLK  in  1  system clock, 100 MHz
- RST  in  1  reset, asynchronous, active-high
- CMD_VALID  in  1  command request
- CMD_READY  out  1  sequencer idle; command accepted on CMD_VALID&&CMD_READY
- CMD_OP  in  2  00 write, 01 read, 10 rewind, 11 no-op
- CMD_WDATA  in  DATA_W  write word, captured at accept
- RSP_VALID  out  1  one-cycle pulse, read data valid
- RSP_RDATA  out  DATA_W  read word, held until next read sample
- ADDR  out  ADDR_W  address the external counter currently presents
- COUNTER_CLK  out  1  counter clock; the counter advances on the falling edge
- COUNTER_RST  out  1  counter reset, active-high
- WE_BAR  out  1  SRAM write enable, active-low
- DATA_OE  out  1  drive enable for the data pins
- DATA_OUT  out  DATA_W  value to drive when DATA_OE=1
- DATA_IN  in  DATA_W  pin sample

## Operation
- States: INIT_RST, IDLE, W_SETUP, W_STROBE, W_HOLD, R_WAIT, ADV_HI, ADV_LO, RWD.
- Reset (async) values: state INIT_RST, CMD_READY=0, RSP_VALID=0, RSP_RDATA=0, ADDR=0, COUNTER_CLK=0, COUNTER_RST=1, WE_BAR=1, DATA_OE=0, DATA_OUT=0, timer=CNT_HALF-1.
- INIT_RST: hold COUNTER_RST=1 for CNT_HALF cycles after reset release, then go to IDLE.
- IDLE: CMD_READY=1. Accept moves to W_SETUP / R_WAIT / RWD. A no-op is accepted and the sequencer stays in IDLE.
- W_SETUP: DATA_OE=1, DATA_OUT=captured word, WE_BAR=1 for SETUP_CYC cycles.
- W_STROBE: WE_BAR=0 for WE_CYC cycles, data still driven.
- W_HOLD: WE_BAR=1 and data still driven for 1 cycle, then ADV_HI.
- R_WAIT: DATA_OE=0, WE_BAR=1 for READ_CYC cycles. On the last cycle, register DATA_IN into RSP_RDATA and pulse RSP_VALID in the following cycle. Then ADV_HI.
- ADV_HI: COUNTER_CLK=1 for CNT_HALF cycles, DATA_OE=0.
- ADV_LO: COUNTER_CLK=0 for CNT_HALF cycles. On entry, ADDR ← ADDR+1 mod 2^ADDR_W (matches the falling edge). Then IDLE.
- RWD: COUNTER_RST=1 for CNT_HALF cycles, ADDR ← 0 on entry. Then IDLE.
- DATA_OE and WE_BAR=0 are never asserted in the same cycle as COUNTER_CLK or COUNTER_RST=1.
- CMD_VALID outside IDLE is ignored. CMD inputs may change freely while busy.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Write: accept at edge 0. CMD_READY returns after SETUP_CYC+WE_CYC+1+2·CNT_HALF cycles (107 with defaults).
- Read: RSP_VALID in cycle READ_CYC+1 after accept. CMD_READY returns after READ_CYC+2·CNT_HALF cycles (103).
- Rewind: CMD_READY returns after CNT_HALF cycles (50).
- Boundaries:
  - ADDR wraps 15→0 with no flag.
  - RST mid-operation forces all reset values immediately: WE_BAR=1 and DATA_OE=0 asynchronously, and the counter is re-cleared via INIT_RST.
  - Back-to-back commands are allowed with CMD_READY one cycle later.

## Structure
- Package sram_demo_pkg holds the CMD_OP encodings (OP_WRITE, OP_READ, OP_REWIND, OP_NOP) and the state enum. The top FSM uses the same package.
- Sub-module phase_timer: loadable down-counter with a done flag, width $clog2(max(CNT_HALF,SETUP_CYC,WE_CYC,READ_CYC))+1. It is shared by all timed states.

## Test plan
- Reset release -> COUNTER_RST=1 for 50 cycles, then CMD_READY=1, ADDR=0, WE_BAR=1, DATA_OE=0.
- Write 0xA5 -> DATA_OUT=0xA5 with DATA_OE=1 for 7 cycles; WE_BAR low for exactly cycles 3–6 after accept; one COUNTER_CLK pulse 50 high / 50 low; ADDR=1; CMD_READY at cycle 107.
- SRAM model, 16 writes 0x00..0x0F, rewind, 16 reads -> RSP_RDATA sequence 0x00..0x0F, one RSP_VALID each, ADDR wraps to 0 after the 16th.
- CMD_VALID held high during a write with OP=read -> ignored until CMD_READY; exactly one command accepted per ready cycle.
- RST asserted while WE_BAR=0 -> WE_BAR=1 and DATA_OE=0 in the same cycle; after release, COUNTER_RST pulse of 50 cycles and ADDR=0.
- OP=11 -> accepted, no pin activity, CMD_READY high the next cycle, ADDR unchanged.

Source files
------------

// File: rtl/sram_demo_pkg.sv
// rtl/sram_demo_pkg.sv - command encodings and sequencer state enum for the SRAM/counter demo
package sram_demo_pkg;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_REWIND = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;

    typedef enum logic [3:0] {
        INIT_RST,
        IDLE,
        W_SETUP,
        W_STROBE,
        W_HOLD,
        R_WAIT,
        ADV_HI,
        ADV_LO,
        RWD
    } seq_state_t;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter shared by all timed sequencer phases
module phase_timer #(
    parameter int             W       = 7,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    // Holds at zero so a phase that waits on done stays put until reloaded.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/sram_access_seq.sv
// rtl/sram_access_seq.sv - pin-level SRAM write/read/rewind sequencer driving WE_BAR, data enable and MC14040B counter
module sram_access_seq
    import sram_demo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int CNT_HALF  = 50,
    parameter int SETUP_CYC = 2,
    parameter int WE_CYC    = 4,
    parameter int READ_CYC  = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_OP,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic [ADDR_W-1:0] ADDR,
    output logic              COUNTER_CLK,
    output logic              COUNTER_RST,
    output logic              WE_BAR,
    output logic              DATA_OE,
    output logic [DATA_W-1:0] DATA_OUT,
    input  logic [DATA_W-1:0] DATA_IN
);

    localparam int TW = $clog2(max_of4(CNT_HALF, SETUP_CYC, WE_CYC, READ_CYC)) + 1;
    localparam logic [TW-1:0] T_HALF  = TW'(CNT_HALF - 1);
    localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] T_WE    = TW'(WE_CYC - 1);
    localparam logic [TW-1:0] T_READ  = TW'(READ_CYC - 1);

    seq_state_t    state;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    phase_timer #(
        .W       (TW),
        .RST_VAL (T_HALF)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Each phase lasts (loaded value + 1) cycles; the load happens on the edge leaving the previous phase.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                if (CMD_VALID) begin
                    tmr_load = (CMD_OP != OP_NOP);
                    case (CMD_OP)
                        OP_WRITE: tmr_val = T_SETUP;
                        OP_READ:  tmr_val = T_READ;
                        default:  tmr_val = T_HALF;
                    endcase
                end
            end
            W_SETUP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = T_WE;
                end
            end
            W_STROBE: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = '0;
                end
            end
            W_HOLD: begin
                tmr_load = 1'b1;
                tmr_val  = T_HALF;
            end
            R_WAIT, ADV_HI: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = T_HALF;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= INIT_RST;
            CMD_READY   <= 1'b0;
            RSP_VALID   <= 1'b0;
            RSP_RDATA   <= '0;
            ADDR        <= '0;
            COUNTER_CLK <= 1'b0;
            COUNTER_RST <= 1'b1;
            WE_BAR      <= 1'b1;
            DATA_OE     <= 1'b0;
            DATA_OUT    <= '0;
        end else begin
            RSP_VALID <= 1'b0;
            case (state)
                INIT_RST: begin
                    if (tmr_done) begin
                        state       <= IDLE;
                        COUNTER_RST <= 1'b0;
                        CMD_READY   <= 1'b1;
                    end
                end
                IDLE: begin
                    if (CMD_VALID) begin
                        case (CMD_OP)
                            OP_WRITE: begin
                                state     <= W_SETUP;
                                CMD_READY <= 1'b0;
                                DATA_OE   <= 1'b1;
                                DATA_OUT  <= CMD_WDATA;
                            end
                            OP_READ: begin
                                state     <= R_WAIT;
                                CMD_READY <= 1'b0;
                            end
                            OP_REWIND: begin
                                state       <= RWD;
                                CMD_READY   <= 1'b0;
                                COUNTER_RST <= 1'b1;
                                ADDR        <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                W_SETUP: begin
                    if (tmr_done) begin
                        state  <= W_STROBE;
                        WE_BAR <= 1'b0;
                    end
                end
                W_STROBE: begin
                    if (tmr_done) begin
                        state  <= W_HOLD;
                        WE_BAR <= 1'b1;
                    end
                end
                W_HOLD: begin
                    state       <= ADV_HI;
                    DATA_OE     <= 1'b0;
                    COUNTER_CLK <= 1'b1;
                end
                R_WAIT: begin
                    if (tmr_done) begin
                        state       <= ADV_HI;
                        RSP_RDATA   <= DATA_IN;
                        RSP_VALID   <= 1'b1;
                        COUNTER_CLK <= 1'b1;
                    end
                end
                ADV_HI: begin
                    // The counter advances on the falling edge, so ADDR follows it here.
                    if (tmr_done) begin
                        state       <= ADV_LO;
                        COUNTER_CLK <= 1'b0;
                        ADDR        <= ADDR + 1'b1;
                    end
                end
                ADV_LO: begin
                    if (tmr_done) begin
                        state     <= IDLE;
                        CMD_READY <= 1'b1;
                    end
                end
                RWD: begin
                    if (tmr_done) begin
                        state       <= IDLE;
                        COUNTER_RST <= 1'b0;
                        CMD_READY   <= 1'b1;
                    end
                end
                default: state <= INIT_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_seq.sv
// tb/tb_sram_access_seq.sv - self-checking bench for sram_access_seq against a timeline model
module tb_sram_access_seq;
    import sram_demo_pkg::*;

    localparam int H      = 50;
    localparam int SU     = 2;
    localparam int WEC    = 4;
    localparam int RC     = 3;
    localparam int WR_DUR = SU + WEC + 1 + 2 * H;
    localparam int RD_DUR = RC + 2 * H;
    localparam int RW_DUR = H;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       CMD_VALID = 1'b0;
    logic [1:0] CMD_OP = OP_NOP;
    logic [7:0] CMD_WDATA = 8'h00;
    logic       CMD_READY, RSP_VALID, COUNTER_CLK, COUNTER_RST, WE_BAR, DATA_OE;
    logic [7:0] RSP_RDATA, DATA_OUT, DATA_IN;
    logic [3:0] ADDR;

    sram_access_seq dut (
        .CLK         (CLK),
        .RST         (RST),
        .CMD_VALID   (CMD_VALID),
        .CMD_READY   (CMD_READY),
        .CMD_OP      (CMD_OP),
        .CMD_WDATA   (CMD_WDATA),
        .RSP_VALID   (RSP_VALID),
        .RSP_RDATA   (RSP_RDATA),
        .ADDR        (ADDR),
        .COUNTER_CLK (COUNTER_CLK),
        .COUNTER_RST (COUNTER_RST),
        .WE_BAR      (WE_BAR),
        .DATA_OE     (DATA_OE),
        .DATA_OUT    (DATA_OUT),
        .DATA_IN     (DATA_IN)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Board-side SRAM seen through the counter address.
    logic [7:0] sram [16];
    assign DATA_IN = sram[ADDR];
    always @(negedge CLK)
        if (!WE_BAR && DATA_OE) sram[ADDR] = DATA_OUT;

    // Model: each command is a fixed timeline measured in cycles since acceptance.
    typedef enum {M_INIT, M_IDLE, M_BUSY} mph_t;
    mph_t       ph = M_INIT;
    int         k = 0;
    int         init_cnt = 0;
    logic [1:0] mop = OP_NOP;
    logic [7:0] mwd = 8'h00;
    logic [7:0] m_rdata = 8'h00;
    logic [3:0] a0 = 4'h0;
    logic [3:0] m_addr = 4'h0;
    logic [7:0] m_mem [16];

    function automatic int dur(input logic [1:0] op);
        if (op == OP_WRITE) return WR_DUR;
        if (op == OP_READ) return RD_DUR;
        return RW_DUR;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ph = M_INIT; init_cnt = 0; m_addr = 4'h0; m_rdata = 8'h00; k = 0;
        end else begin
            case (ph)
                M_INIT: begin
                    init_cnt++;
                    if (init_cnt == H) ph = M_IDLE;
                end
                M_IDLE: begin
                    if (CMD_VALID && CMD_OP != OP_NOP) begin
                        ph = M_BUSY; k = 1; mop = CMD_OP; mwd = CMD_WDATA; a0 = m_addr;
                        if (CMD_OP == OP_WRITE) m_mem[m_addr] = CMD_WDATA;
                    end
                end
                default: begin
                    if (k == dur(mop)) begin
                        ph = M_IDLE;
                        m_addr = (mop == OP_REWIND) ? 4'h0 : a0 + 4'd1;
                        if (mop == OP_READ) m_rdata = m_mem[a0];
                    end else begin
                        k++;
                    end
                end
            endcase
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            logic       busy, e_oe, e_we, e_clk, e_crst, e_rv;
            logic [7:0] e_rd;
            logic [3:0] e_addr;
            busy   = (ph == M_BUSY);
            e_oe   = busy && mop == OP_WRITE && k <= SU + WEC + 1;
            e_we   = !(busy && mop == OP_WRITE && k > SU && k <= SU + WEC);
            e_clk  = busy && ((mop == OP_WRITE && k > SU + WEC + 1 && k <= SU + WEC + 1 + H) ||
                              (mop == OP_READ && k > RC && k <= RC + H));
            e_crst = (ph == M_INIT) || (busy && mop == OP_REWIND);
            e_rv   = busy && mop == OP_READ && k == RC + 1;
            e_rd   = (busy && mop == OP_READ && k > RC) ? m_mem[a0] : m_rdata;
            if (!busy) e_addr = m_addr;
            else if (mop == OP_REWIND) e_addr = 4'h0;
            else if (mop == OP_WRITE) e_addr = (k > SU + WEC + 1 + H) ? a0 + 4'd1 : a0;
            else e_addr = (k > RC + H) ? a0 + 4'd1 : a0;
            check("cmd_ready", CMD_READY, ph == M_IDLE);
            check("we_bar", WE_BAR, e_we);
            check("data_oe", DATA_OE, e_oe);
            check("counter_clk", COUNTER_CLK, e_clk);
            check("counter_rst", COUNTER_RST, e_crst);
            check("rsp_valid", RSP_VALID, e_rv);
            check("rsp_rdata", RSP_RDATA, e_rd);
            check("addr", ADDR, e_addr);
            if (e_oe) check("data_out", DATA_OUT, mwd);
        end
    end

    logic       cap_en = 1'b0;
    logic [7:0] rq [$];
    always @(negedge CLK)
        if (cap_en && RSP_VALID) rq.push_back(RSP_RDATA);

    task automatic issue(input logic [1:0] op, input logic [7:0] wd);
        int n = 0;
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD_OP = op; CMD_WDATA = wd;
        while (!CMD_READY && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 400) begin
            check("issue_timeout", n, 0);
            CMD_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0; CMD_OP = 2'($urandom); CMD_WDATA = 8'($urandom);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!CMD_READY && n < 400) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (n >= 400) check("ready_timeout", n, 0);
    endtask

    initial begin
        int n, oe, wfirst, wlast, rdy, clkhi;
        for (int i = 0; i < 16; i++) begin
            sram[i] = 8'h00;
            m_mem[i] = 8'h00;
        end
        #1 RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        wait_ready(n);
        check("init_rst_len", n, 50);
        check("init_addr", ADDR, 0);
        check("init_we_bar", WE_BAR, 1);
        check("init_data_oe", DATA_OE, 0);
        check("init_counter_rst", COUNTER_RST, 0);

        issue(OP_WRITE, 8'hA5);
        oe = 0; wfirst = 0; wlast = 0; rdy = 0; clkhi = 0;
        for (int c = 1; c <= 110; c++) begin
            @(negedge CLK);
            if (DATA_OE && DATA_OUT == 8'hA5) oe++;
            if (!WE_BAR) begin
                if (wfirst == 0) wfirst = c;
                wlast = c;
            end
            if (COUNTER_CLK) clkhi++;
            if (CMD_READY && rdy == 0) rdy = c;
        end
        check("wr_oe_cycles", oe, 7);
        check("wr_we_first", wfirst, 3);
        check("wr_we_last", wlast, 6);
        check("wr_clk_high", clkhi, 50);
        check("wr_busy_cycles", rdy - 1, 107);
        check("wr_addr", ADDR, 1);

        issue(OP_NOP, 8'h00);
        @(negedge CLK);
        check("nop_ready", CMD_READY, 1);
        check("nop_addr", ADDR, 1);
        check("nop_pins", {COUNTER_CLK, COUNTER_RST, DATA_OE, WE_BAR}, 4'b0001);

        // Read held pending through the whole write: exactly two accepts.
        issue(OP_WRITE, 8'h3C);
        issue(OP_READ, 8'h00);
        wait_ready(n);
        check("held_addr", ADDR, 3);

        issue(OP_WRITE, 8'h77);
        n = 0;
        while (WE_BAR && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("we_low_seen", WE_BAR, 0);
        #2 RST = 1'b1;
        #1;
        check("rst_we_bar", WE_BAR, 1);
        check("rst_data_oe", DATA_OE, 0);
        check("rst_counter_rst", COUNTER_RST, 1);
        @(negedge CLK);
        RST = 1'b0;
        wait_ready(n);
        check("rst_init_len", n, 50);
        check("rst_addr", ADDR, 0);

        issue(OP_REWIND, 8'h00);
        for (int i = 0; i < 16; i++) issue(OP_WRITE, 8'(i));
        issue(OP_REWIND, 8'h00);
        wait_ready(n);
        check("rewind_addr", ADDR, 0);
        cap_en = 1'b1;
        for (int i = 0; i < 16; i++) issue(OP_READ, 8'h00);
        wait_ready(n);
        cap_en = 1'b0;
        check("rd_count", rq.size(), 16);
        for (int i = 0; i < 16 && i < rq.size(); i++) check("rd_seq", rq[i], i);
        check("rd_wrap_addr", ADDR, 0);

        repeat (4000) begin
            @(negedge CLK);
            CMD_VALID = ($urandom_range(0, 3) != 0);
            CMD_OP    = 2'($urandom);
            CMD_WDATA = 8'($urandom);
        end
        @(negedge CLK);
        CMD_VALID = 1'b0;
        wait_ready(n);
        repeat (2) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
